calc_fsm_chain: RTL
===================

CALC_FSM_CHAIN -- requirements
Module: calc_fsm_chain

Interface
REQ-001 Parameter W SHALL default 16; it is the operand width and the SW width.
REQ-002 Parameter OPW SHALL default 4; it is the opcode width, taken from SW[OPW-1:0], with OPW <= W.
REQ-003 Parameter RW SHALL default W+1; it is the ALU result width.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 BTNC  in  1  advance/confirm button, debounced, level.
REQ-007 BTNL  in  1  undo button, debounced, level.
REQ-008 BTNR  in  1  chain button (reuse result as operand A), debounced, level.
REQ-009 SW  in  W  operand/opcode switches.
REQ-010 resultado  in  RW  ALU result, valid when alu_done=1.
REQ-011 alu_done  in  1  ALU completion strobe.
REQ-012 op_a, op_b  out  W each  registered operands to ALU.
REQ-013 op_code  out  OPW  registered opcode to ALU.
REQ-014 alu_start  out  1  one-cycle ALU request pulse.
REQ-015 salida_display  out  RW  value to display driver.
REQ-016 power_on  out  1  display enable.
REQ-017 estado  out  3  current state code.

Function
REQ-018 Edge detect: each button SHALL register its previous level, with edge = level & ~previous; all actions in REQ-020..REQ-027 SHALL occur on the clock edge where the edge term is 1.
REQ-019 Simultaneous edges in one cycle SHALL take no action, except that BTNR in SHOW_RESULT takes priority when alone with neither BTNC nor BTNL.
REQ-020 States and codes: WAIT_OP1=0, WAIT_OP2=1, WAIT_OP=2, SHOW_RESULT=3, CALC=4; codes 5-7 SHALL go to WAIT_OP1 on the next edge; estado SHALL equal the state code.
REQ-021 WAIT_OP1: on BTNC, op_a <= SW and go to WAIT_OP2; BTNL SHALL do nothing.
REQ-022 WAIT_OP2: on BTNC, op_b <= SW and go to WAIT_OP; on BTNL, go to WAIT_OP1.
REQ-023 WAIT_OP: on BTNC, op_code <= SW[OPW-1:0] and go to CALC; on BTNL, go to WAIT_OP2.
REQ-024 CALC: alu_start SHALL be 1 in exactly the first cycle of each CALC entry; on alu_done=1 (including that first cycle), res <= resultado and go to SHOW_RESULT; all button edges SHALL be discarded.
REQ-025 SHOW_RESULT: on BTNC, go to WAIT_OP1; on BTNL, go to WAIT_OP; on BTNR, op_a <= res[W-1:0] (upper bits dropped) and go to WAIT_OP2.
REQ-026 Undo SHALL NOT clear registers; a re-entered state overwrites its register only on the next BTNC.
REQ-027 alu_done outside CALC SHALL be ignored; res SHALL change only in CALC.
REQ-028 salida_display SHALL be SW zero-extended to RW in WAIT_OP1, WAIT_OP2 and WAIT_OP, and res in CALC and SHOW_RESULT.
REQ-029 power_on SHALL be 0 in WAIT_OP and 1 in all other states.
REQ-030 CALC SHALL wait for alu_done indefinitely; reset is the only exit without it.

Reset
REQ-031 Reset SHALL force state WAIT_OP1 and clear op_a, op_b, op_code, res and alu_start to 0.
REQ-032 Reset SHALL load all button-history registers with 1, so a button held through reset gives no edge until it is released and pressed again.
REQ-033 Reset asserted mid-CALC SHALL abort the operation; a later alu_done SHALL be ignored.
REQ-034 The outputs SHALL reflect the reset values in the cycle after the reset edge.

Verification
REQ-035 Full pass: SW=5, BTNC; SW=3, BTNC; SW=1, BTNC; alu_done=1 with resultado=8 in the second CALC cycle -> op_a=5, op_b=3, op_code=1, alu_start pulses one cycle, state 3, display 8.
REQ-036 Undo chain: from SHOW_RESULT press BTNL three times -> states 2, 1, 0, power_on 0 only in state 2, op_a/op_b/op_code unchanged.
REQ-037 Chain: res=0x1_0004 at W=16; BTNR -> op_a=0x0004, state 1; BTNC with SW=2 -> op_b=2, state 2.
REQ-038 Collisions: BTNC and BTNL rise together in WAIT_OP2 -> no change; BTNC held 20 cycles -> exactly one advance; edges in CALC -> ignored.
REQ-039 Reset cases: reset during CALC then alu_done -> state 0, res=0; BTNC held across reset release -> stays in state 0 until re-pressed.

Source files
------------

// File: rtl/calc_fsm_chain.sv
// +----------------------------------------------------------------------------+
// | Module  : calc_fsm_chain                                                   |
// | Brief   : Button-driven operand/opcode sequencer for an external ALU,      |
// |           with undo, result chaining and display selection.                |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module calc_fsm_chain #(
    parameter int W   = 16,
    parameter int OPW = 4,
    parameter int RW  = W + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           BTNC,
    input  logic           BTNL,
    input  logic           BTNR,
    input  logic [W-1:0]   SW,
    input  logic [RW-1:0]  resultado,
    input  logic           alu_done,
    output logic [W-1:0]   op_a,
    output logic [W-1:0]   op_b,
    output logic [OPW-1:0] op_code,
    output logic           alu_start,
    output logic [RW-1:0]  salida_display,
    output logic           power_on,
    output logic [2:0]     estado
);

    localparam logic [2:0] c_WAIT_OP1    = 3'd0;
    localparam logic [2:0] c_WAIT_OP2    = 3'd1;
    localparam logic [2:0] c_WAIT_OP     = 3'd2;
    localparam logic [2:0] c_SHOW_RESULT = 3'd3;
    localparam logic [2:0] c_CALC        = 3'd4;

    logic [2:0]     r_state;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic [OPW-1:0] r_op_code;
    logic [RW-1:0]  r_res;
    logic           r_alu_start;
    logic           r_btnc_q;
    logic           r_btnl_q;
    logic           r_btnr_q;

    logic           w_c_edge;
    logic           w_l_edge;
    logic           w_r_edge;
    logic           w_c_only;
    logic           w_l_only;
    logic           w_r_only;
    logic [RW-1:0]  w_sw_ext;

    assign w_c_edge = BTNC & ~r_btnc_q;
    assign w_l_edge = BTNL & ~r_btnl_q;
    assign w_r_edge = BTNR & ~r_btnr_q;

    // Any two edges landing in the same cycle cancel each other out.
    assign w_c_only = w_c_edge & ~w_l_edge & ~w_r_edge;
    assign w_l_only = w_l_edge & ~w_c_edge & ~w_r_edge;
    assign w_r_only = w_r_edge & ~w_c_edge & ~w_l_edge;

    assign w_sw_ext = RW'(SW);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_WAIT_OP1;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_code   <= '0;
            r_res       <= '0;
            r_alu_start <= 1'b0;
            // Held buttons must be released before they can produce an edge.
            r_btnc_q    <= 1'b1;
            r_btnl_q    <= 1'b1;
            r_btnr_q    <= 1'b1;
        end else begin
            r_btnc_q    <= BTNC;
            r_btnl_q    <= BTNL;
            r_btnr_q    <= BTNR;
            r_alu_start <= 1'b0;

            case (r_state)
                c_WAIT_OP1: begin
                    if (w_c_only) begin
                        r_op_a  <= SW;
                        r_state <= c_WAIT_OP2;
                    end
                end

                c_WAIT_OP2: begin
                    if (w_c_only) begin
                        r_op_b  <= SW;
                        r_state <= c_WAIT_OP;
                    end else if (w_l_only) begin
                        r_state <= c_WAIT_OP1;
                    end
                end

                c_WAIT_OP: begin
                    if (w_c_only) begin
                        r_op_code   <= SW[OPW-1:0];
                        r_alu_start <= 1'b1;
                        r_state     <= c_CALC;
                    end else if (w_l_only) begin
                        r_state <= c_WAIT_OP2;
                    end
                end

                c_CALC: begin
                    if (alu_done) begin
                        r_res   <= resultado;
                        r_state <= c_SHOW_RESULT;
                    end
                end

                c_SHOW_RESULT: begin
                    if (w_c_only) begin
                        r_state <= c_WAIT_OP1;
                    end else if (w_l_only) begin
                        r_state <= c_WAIT_OP;
                    end else if (w_r_only) begin
                        r_op_a  <= r_res[W-1:0];
                        r_state <= c_WAIT_OP2;
                    end
                end

                default: begin
                    r_state <= c_WAIT_OP1;
                end
            endcase
        end
    end

    always_comb begin
        salida_display = w_sw_ext;
        power_on       = 1'b1;
        case (r_state)
            c_CALC, c_SHOW_RESULT: salida_display = r_res;
            c_WAIT_OP:             power_on       = 1'b0;
            default:               salida_display = w_sw_ext;
        endcase
    end

    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign op_code   = r_op_code;
    assign alu_start = r_alu_start;
    assign estado    = r_state;

endmodule

`default_nettype wire
